// File: rtl/muldiv_sequencer_if.sv
// HI/LO unit bundle between the EX stage and the multiply/divide sequencer.
// EX drives requests and operands; the sequencer returns status and HI/LO state.
interface muldiv_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [1:0]  mt_we;
  logic        mf_req;
  logic        mf_sel;
  logic        busy;
  logic        stall;
  logic [31:0] mf_data;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    output mt_we, mf_req, mf_sel,
    input  busy, stall, mf_data, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    input  mt_we, mf_req, mf_sel,
    output busy, stall, mf_data, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Fixed-latency MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Result is computed at issue and committed to HI/LO when the latency expires.
module muldiv_sequencer #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic reset,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t      r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [31:0] r_hi, w_hi;
  logic [31:0] r_lo, w_lo;
  logic [31:0] r_res_hi, w_res_hi;
  logic [31:0] r_res_lo, w_res_lo;

  logic        w_sgn;
  logic [63:0] w_ma, w_mb, w_prod;
  logic        w_sa, w_sb;
  logic [31:0] w_da, w_db, w_uq, w_ur;
  logic [31:0] w_q, w_r;
  logic        w_req;

  // Signed product via sign-extension: low 64 bits are exact.
  always_comb begin
    w_sgn  = ~bus.op[0];
    w_ma   = {{32{w_sgn & bus.rs_val[31]}}, bus.rs_val};
    w_mb   = {{32{w_sgn & bus.rt_val[31]}}, bus.rt_val};
    w_prod = w_ma * w_mb;
  end

  // Divide magnitudes, then fix signs; 0x80000000/-1 falls out naturally.
  always_comb begin
    w_sa = w_sgn & bus.rs_val[31];
    w_sb = w_sgn & bus.rt_val[31];
    w_da = w_sa ? -bus.rs_val : bus.rs_val;
    w_db = w_sb ? -bus.rt_val : bus.rt_val;
    w_uq = '0;
    w_ur = '0;
    if (w_db != 32'd0) begin
      w_uq = w_da / w_db;
      w_ur = w_da % w_db;
    end
    w_q = (w_sa ^ w_sb) ? -w_uq : w_uq;
    w_r = w_sa ? -w_ur : w_ur;
    if (bus.rt_val == 32'd0) begin
      w_q = 32'hFFFF_FFFF;
      w_r = bus.rs_val;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_hi     = r_hi;
    w_lo     = r_lo;
    w_res_hi = r_res_hi;
    w_res_lo = r_res_lo;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state = S_BUSY;
          if (bus.op[1]) begin
            w_res_hi = w_r;
            w_res_lo = w_q;
            w_cnt    = CNT_W'(DIV_LAT - 1);
          end else begin
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
            w_cnt    = CNT_W'(MUL_LAT - 1);
          end
        end else if (bus.mt_we == 2'b01) begin
          w_lo = bus.rs_val;
        end else if (bus.mt_we == 2'b10) begin
          w_hi = bus.rs_val;
        end
      end
      S_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else begin
          w_hi    = r_res_hi;
          w_lo    = r_res_lo;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_hi     <= w_hi;
      r_lo     <= w_lo;
      r_res_hi <= w_res_hi;
      r_res_lo <= w_res_lo;
    end
  end

  assign w_req = bus.start | bus.mf_req |
                 (bus.mt_we == 2'b01) | (bus.mt_we == 2'b10);

  assign bus.busy    = (r_state == S_BUSY);
  assign bus.stall   = bus.busy & w_req;
  assign bus.mf_data = bus.mf_sel ? r_hi : r_lo;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;

endmodule
